// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line rate.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int unsigned UART_DEFAULT_BAUD = 115200;

endpackage

// File: rtl/uart_sync.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
// RESET_VAL is the value both flops take in reset (use the idle level of the signal).
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled frame recovery, LSB first, one start and one stop bit,
// valid/ready word output and one-cycle error pulses.
// Optional even parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKRATE     = 100000000,
  parameter int unsigned BAUD        = UART_DEFAULT_BAUD,
  parameter int unsigned WORD_LENGTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   UART_RX,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_data_valid,
  input  logic                   rx_data_ready,
  output logic                   rx_frame_error,
  output logic                   rx_parity_error,
  output logic                   rx_overrun
);

  localparam int unsigned CLKS_PER_BIT = CLKRATE / BAUD;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_LENGTH - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx: CLKRATE / BAUD must be at least 4");
    end
  endgenerate

  uart_rx_state_t state, state_next;

  logic                   line_s;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [IDX_W-1:0]       idx, idx_next;
  logic [WORD_LENGTH-1:0] shreg, shreg_next;
  logic                   load, ovr_next, fe_next;
  logic                   tick_half, tick_bit, out_free;

  uart_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (UART_RX),
    .q    (line_s)
  );

  assign tick_half = (cnt == HALF_LAST);
  assign tick_bit  = (cnt == BIT_LAST);
  // A word may load if the holding register is empty or drains on this very edge
  assign out_free  = !rx_data_valid || rx_data_ready;

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_next, pe_next, parity_ok;
  // Even parity: data bits plus parity bit must XOR to zero
  assign parity_ok = ~^{shreg, par_bit};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!line_s) state_next = START;
      START:     if (tick_half) state_next = line_s ? IDLE : DATA;
      DATA: begin
        if (tick_bit && (idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (tick_bit) state_next = STOP;
`endif
      // A low stop bit may be a break; hold off until the line idles again
      STOP:      if (tick_bit) state_next = line_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (line_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath next values and output events
  always_comb begin
    cnt_next   = cnt + CNT_W'(1);
    idx_next   = idx;
    shreg_next = shreg;
    load       = 1'b0;
    ovr_next   = 1'b0;
    fe_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_next   = par_bit;
    pe_next    = 1'b0;
`endif
    case (state)
      IDLE: cnt_next = '0;
      START: begin
        if (tick_half) begin
          cnt_next = '0;
          idx_next = '0;
        end
      end
      DATA: begin
        if (tick_bit) begin
          cnt_next   = '0;
          idx_next   = idx + IDX_W'(1);
          // LSB arrives first, so shift in from the top
          shreg_next = (shreg >> 1) | (WORD_LENGTH'(line_s) << (WORD_LENGTH - 1));
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_bit) begin
          cnt_next = '0;
          par_next = line_s;
        end
      end
`endif
      STOP: begin
        if (tick_bit) begin
          cnt_next = '0;
          if (!line_s) begin
            fe_next = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (!parity_ok) begin
            pe_next = 1'b1;
`endif
          end else if (out_free) begin
            load = 1'b1;
          end else begin
            ovr_next = 1'b1;
          end
        end
      end
      default: cnt_next = '0;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      idx            <= '0;
      shreg          <= '0;
      rx_data        <= '0;
      rx_data_valid  <= 1'b0;
      rx_frame_error <= 1'b0;
      rx_overrun     <= 1'b0;
    end else begin
      cnt            <= cnt_next;
      idx            <= idx_next;
      shreg          <= shreg_next;
      rx_frame_error <= fe_next;
      rx_overrun     <= ovr_next;
      if (load) begin
        rx_data <= shreg;
      end
      rx_data_valid  <= load | (rx_data_valid & ~rx_data_ready);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity sample and parity error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit         <= 1'b0;
      rx_parity_error <= 1'b0;
    end else begin
      par_bit         <= par_next;
      rx_parity_error <= pe_next;
    end
  end
`else
  assign rx_parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: latency, table of single frames, multi-cycle corner
// cases (glitch, overrun, reset mid-frame) and a randomized frame stream checked
// against a frame-level model.
module tb_uart_rx;

  localparam int unsigned CLKRATE = 1000000;
  localparam int unsigned BAUD    = 100000;
  localparam int          C       = 10;
  localparam int          H       = 5;
  localparam int          W       = 8;
`ifdef UART_RX_PARITY_EN
  localparam int          P       = 1;
`else
  localparam int          P       = 0;
`endif
  localparam int          LAT     = 2 + 1 + H + (W + 1 + P) * C + 1;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    bit         par_flip;
    bit         exp_word;
    bit         exp_fe;
    bit         exp_pe;
  } frame_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       line  = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] rx_data;
  logic       valid, fe, pe, ovr;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(
    .CLKRATE    (CLKRATE),
    .BAUD       (BAUD),
    .WORD_LENGTH(W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .UART_RX        (line),
    .rx_data        (rx_data),
    .rx_data_valid  (valid),
    .rx_data_ready  (ready),
    .rx_frame_error (fe),
    .rx_parity_error(pe),
    .rx_overrun     (ovr)
  );

  always #5 clk = ~clk;

  // Monitor: collect transferred words and error pulses, away from the active edge
  logic [7:0] got_q[$];
  int fe_cnt = 0, pe_cnt = 0, ovr_cnt = 0, wide_cnt = 0, excl_cnt = 0;
  logic fe_d = 1'b0, pe_d = 1'b0, ovr_d = 1'b0;

  always @(negedge clk) begin
    if (valid && ready) got_q.push_back(rx_data);
    if (fe) fe_cnt++;
    if (pe) pe_cnt++;
    if (ovr) ovr_cnt++;
    if ((fe && fe_d) || (pe && pe_d) || (ovr && ovr_d)) wide_cnt++;
    if (int'(fe) + int'(pe) + int'(ovr) > 1) excl_cnt++;
    fe_d  = fe;
    pe_d  = pe;
    ovr_d = ovr;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation still running after 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    line = b;
    repeat (C) tick();
  endtask

  // Frame on the pin; a bad stop is held low for two bit-times before the line idles
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip);
    send_bit(1'b0);
    for (int i = 0; i < W; i++) send_bit(d[i]);
    if (P != 0) send_bit(^d ^ par_flip);
    if (stop_ok) begin
      send_bit(1'b1);
    end else begin
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
    end
  endtask

  // Compare the number of words received since the last call and the word itself
  task automatic check_rx(input string name, input int exp_n, input logic [7:0] exp_word);
    check({name, "_count"}, got_q.size(), exp_n);
    if (got_q.size() > 0) begin
      logic [7:0] w;
      w = got_q.pop_front();
      if (exp_n > 0) check({name, "_data"}, w, exp_word);
    end
    got_q.delete();
  endtask

  initial begin
    frame_t     tbl[$];
    int         first, nhigh;
    int         b_fe, b_pe, b_ovr;
    int         efe, epe;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    bit         sok, pf;

    // Reset state
    repeat (3) tick();
    check("reset_data", rx_data, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_errs", {fe, pe, ovr}, 3'b000);
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_reset_valid", valid, 1'b0);

    // Single byte with latency and one-cycle valid
    ready = 1'b1;
    first = -1;
    nhigh = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      for (int n = 1; n <= LAT + 20; n++) begin
        tick();
        if (valid) begin
          if (first < 0) first = n;
          nhigh++;
        end
      end
    join
    // valid registers on the stop-sample edge; a posedge-sampling consumer sees it at LAT
    check("latency", first, LAT - 1);
    check("valid_width", nhigh, 1);
    check_rx("a5", 1, 8'hA5);

    // Table of single frames
    tbl.push_back('{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'h03, 1'b1, 1'b1, (P == 0), 1'b0, (P == 1)});
    tbl.push_back('{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'h81, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    foreach (tbl[i]) begin
      b_fe  = fe_cnt;
      b_pe  = pe_cnt;
      b_ovr = ovr_cnt;
      send_frame(tbl[i].data, tbl[i].stop_ok, tbl[i].par_flip);
      repeat (2 * C) tick();
      check($sformatf("tbl%0d_fe", i), fe_cnt - b_fe, int'(tbl[i].exp_fe));
      check($sformatf("tbl%0d_pe", i), pe_cnt - b_pe, int'(tbl[i].exp_pe));
      check($sformatf("tbl%0d_ovr", i), ovr_cnt - b_ovr, 0);
      check_rx($sformatf("tbl%0d", i), int'(tbl[i].exp_word), tbl[i].data);
    end

    // Glitch shorter than half a bit is ignored
    b_fe = fe_cnt;
    b_pe = pe_cnt;
    line = 1'b0;
    repeat (3) tick();
    line = 1'b1;
    repeat (3 * C) tick();
    check("glitch_errs", (fe_cnt - b_fe) + (pe_cnt - b_pe), 0);
    check_rx("glitch", 0, 8'h00);
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (2 * C) tick();
    check_rx("after_glitch", 1, 8'h3C);

    // Overrun: second frame dropped while the first is still held
    ready = 1'b0;
    b_ovr = ovr_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (C) tick();
    check("ovr_valid_held", valid, 1'b1);
    check("ovr_data_held", rx_data, 8'h00);
    check("ovr_pulse", ovr_cnt - b_ovr, 1);
    ready = 1'b1;
    repeat (2) tick();
    check("ovr_drained", valid, 1'b0);
    check_rx("ovr_word", 1, 8'h00);

    // Reset mid-frame discards the held word and the partial frame
    ready = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    repeat (C) tick();
    check("pre_reset_valid", valid, 1'b1);
    d = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    line = d[4];
    repeat (C / 2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_data", rx_data, 8'h00);
    check("midrst_valid", valid, 1'b0);
    check("midrst_errs", {fe, pe, ovr}, 3'b000);
    line = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2 * C) tick();
    check("after_rst_valid", valid, 1'b0);
    ready = 1'b1;
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (2 * C) tick();
    check_rx("after_rst", 1, 8'h81);

    // Randomized frame stream against a frame-level model
    b_fe  = fe_cnt;
    b_pe  = pe_cnt;
    b_ovr = ovr_cnt;
    efe   = 0;
    epe   = 0;
    got_q.delete();
    for (int k = 0; k < 24; k++) begin
      d   = 8'($urandom);
      sok = ($urandom_range(7) != 0);
      pf  = ($urandom_range(5) == 0);
      if (!sok) efe++;
      else if (P != 0 && pf) epe++;
      else exp_q.push_back(d);
      send_frame(d, sok, pf);
      repeat ($urandom_range(2) * C) tick();
    end
    repeat (2 * C) tick();
    check("rand_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check($sformatf("rand_word%0d", k), got_q[k], exp_q[k]);
    end
    check("rand_fe", fe_cnt - b_fe, efe);
    check("rand_pe", pe_cnt - b_pe, epe);
    check("rand_ovr", ovr_cnt - b_ovr, 0);

    check("pulse_width", wide_cnt, 0);
    check("pulse_exclusive", excl_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that samples the asynchronous UART line, reassembles frames into parallel words and presents them on an AXI-Stream-style valid/ready output. It is the receive-side counterpart of the existing transmit path: the far end's `uart_tx` drives its line, and this block's output feeds a receive FIFO or the user logic. The frame format is 8N1 by default: LSB first, one start bit and one stop bit. Per-frame error flags are provided for framing, overrun and, optionally, parity.

## Interface
- `CLKRATE`, default 100000000: system clock frequency in Hz.
- `BAUD`, default 115200: line bit rate.
- `WORD_LENGTH`, default 8: data bits per frame.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `UART_RX`  in  1  serial line; idles high; asynchronous to `clk`.
- `rx_data`  out  WORD_LENGTH  received word; stable while `rx_data_valid` is high.
- `rx_data_valid`  out  1  word available.
- `rx_data_ready`  in  1  consumer accepts; a transfer occurs on `valid && ready`.
- `rx_frame_error`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_parity_error`  out  1  one-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.
- `rx_overrun`  out  1  one-cycle pulse: a good frame was dropped because the output was still occupied.

## Operation
- `CLKS_PER_BIT = CLKRATE / BAUD`, using integer truncation. `HALF_BIT = CLKS_PER_BIT / 2`.
- The bit counter is `$clog2(CLKS_PER_BIT)` bits wide. Elaboration must fail if `CLKS_PER_BIT < 4`.
- `UART_RX` passes through a 2-flop synchronizer. The synchronizer resets to 1.
- **IDLE**: wait for the synchronized line to be 0, then go to START with the counter cleared.
- **START**: at count `HALF_BIT-1`, sample the line.
  - If 0, go to DATA with counter = 0 and bit index = 0.
  - If 1, treat it as a glitch and return to IDLE.
- **DATA**: sample at count `CLKS_PER_BIT-1`, which is the mid-bit point.
  - Shift each sample in LSB first.
  - After `WORD_LENGTH` samples, go to PARITY if compiled in, otherwise to STOP.
- **PARITY**: sample one bit at the mid-bit point, then go to STOP.
- **STOP**: sample at the mid-bit point.
  - Sample 1 and parity OK:
    - If the output is empty, or is being emptied this cycle (`valid && ready`), load `rx_data` and set `rx_data_valid`.
    - Otherwise drop the word, pulse `rx_overrun`, and leave `rx_data` unchanged.
    - Go to IDLE.
  - Sample 1 and parity bad: pulse `rx_parity_error`, drop the word, go to IDLE.
  - Sample 0: pulse `rx_frame_error`, drop the word, go to WAIT_IDLE. This also covers a break condition.
- **WAIT_IDLE**: stay until the synchronized line is 1, then go to IDLE.
- `rx_data_valid` clears on `valid && ready`, unless a new word loads in the same cycle, in which case it stays high.
- Reset asserted mid-frame: all state returns to reset values immediately; the partial frame is discarded.

## Timing
- Reset values: `rx_data` = 0, `rx_data_valid` = 0, all error pulses = 0, state = IDLE.
- Latency: `rx_data_valid` rises one cycle after the STOP sample. That is 2 (synchronizer) + 1 (IDLE detect) + `HALF_BIT` + (`WORD_LENGTH` + 1 + P) × `CLKS_PER_BIT` + 1 cycles after the falling edge on the pin, where P = 1 with parity and 0 without.
- The receiver returns to IDLE at the stop mid-point. A start bit arriving directly after the stop bit is therefore caught with no lost cycles.
- All outputs are registered; there is no combinational path from `rx_data_ready` to any output.
- The error pulses last exactly one cycle and are mutually exclusive per frame.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- **Defined**: each frame carries one even-parity bit between the data and the stop bit; the PARITY state exists; `rx_parity_error` is live.
- **Undefined**: no parity bit in the frame; the PARITY state is removed; `rx_parity_error` is constant 0.

## Structure
- Shared package `uart_pkg` holds:
  - the `typedef enum logic [2:0] uart_rx_state_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}`;
  - the default `BAUD` constant.
- `CLKS_PER_BIT` and `HALF_BIT` are localparams inside the module.
- One sub-module, `uart_sync`: a generic 2-flop synchronizer with a reset-value parameter. It is reusable elsewhere in the codebase.

## Test plan
All scenarios use `CLKRATE`=1000000 and `BAUD`=100000, so `CLKS_PER_BIT` = 10.
- **Single byte**: drive 0xA5 (8N1) with `ready`=1. Expect `rx_data`=0xA5 and `valid` high for exactly 1 cycle, at the latency given above with P = 0.
- **Overrun**: send 0x00 then 0xFF back-to-back with `ready`=0. Expect `rx_data` to stay 0x00 with `valid` held high, and `rx_overrun` to pulse once at the second STOP sample. Raising `ready` must then empty the output.
- **Glitch**: pull the line low for 3 cycles. Expect no `valid` and no error pulse; a following 0x3C is received correctly.
- **Framing error**: send 0x55 with the stop bit low for 2 bit-times. Expect `rx_frame_error` for 1 cycle, no `valid`, and no new start detected until the line returns high.
- **Parity error** (`UART_RX_PARITY_EN`): send 0x03 with parity bit 1. Expect `rx_parity_error` for 1 cycle and no `valid`. Sending 0x03 with parity bit 0 delivers 0x03.
- **Reset mid-frame**: assert `rst_n`=0 during data bit 4. Expect all outputs at 0 immediately. After release, 0x81 is received correctly.
